mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised iterative RV32M/RV64M execute unit: takes a decoded M-extension operation (funct3 with funct7 = 0000001) and two XLEN-bit operands, and returns the result after a fixed multi-cycle latency. It sits beside the ALU in the execute stage of the pipelined core. The hazard unit stalls the pipeline while `busy` is high, and the result mux takes `result` when `done` pulses. It adds multiply, divide and remainder behaviour that the single-cycle ALU decoder and ALU do not have.

## Interface
- `XLEN`, default 32: operand and result width; must be even and ≥ 4.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while `ready` = 1.
- `funct3`  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a`  in  XLEN  rs1 operand; dividend or multiplicand.
- `src_b`  in  XLEN  rs2 operand; divisor or multiplier.
- `flush`  in  1  synchronous kill of any in-flight operation.
- `ready`  out  1  unit can accept `start`; equals (state ≠ CALC).
- `busy`  out  1  equals (state = CALC).
- `done`  out  1  one-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN  registered result; holds its value until the next `done`.

## Operation
- States: IDLE, CALC, DONE. Reset puts the unit in IDLE with `ready`=1, `busy`=0, `done`=0, `result`=0, step counter = 0.
- Accepting a request: on an edge with `start`=1 and state IDLE or DONE, the unit latches `funct3` and the operand magnitudes, and records the result sign.
  - Signed operands: MUL, MULH, DIV and REM treat both operands as signed. MULHSU treats `src_a` as signed and `src_b` as unsigned. MULHU, DIVU and REMU treat both as unsigned.
  - Result sign: product sign is a^b. Quotient sign is a^b. Remainder sign follows the dividend.
- Multiply path: radix-2 shift-add into a 2·XLEN accumulator, one multiplier bit per CALC cycle, XLEN steps. The sign correction negates the full 2·XLEN value. MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide path: restoring division, one quotient bit per CALC cycle, XLEN steps. Apply the sign correction, then DIV/DIVU return the quotient and REM/REMU return the remainder.
- Fast paths: these are decided at the accept edge, skip CALC and go directly to DONE.
  - Divide by zero: quotient = all ones; remainder = `src_a`.
  - Signed overflow, DIV/REM with `src_a` = 2^(XLEN−1) and `src_b` = −1: quotient = `src_a`; remainder = 0.
- Transitions:
  - IDLE → CALC on `start`, or IDLE → DONE on a fast path.
  - CALC → DONE on the edge that performs step XLEN−1; `result` is loaded on that same edge.
  - DONE → CALC, or DONE → DONE via a fast path, on `start`; otherwise DONE → IDLE.
- `start` while in CALC is ignored. It is not queued, and the caller must hold the request.
- `flush`=1 on an edge forces IDLE with `done`=0 next cycle and leaves `result` unchanged. `flush` beats `start` on the same edge.
- Reset asserted mid-operation immediately returns all state and outputs to their reset values.

## Timing
- Accept edge E0. Normal ops: `busy`=1 from E0 to E_XLEN, and `done`=1 in the cycle after edge E_XLEN. That is a latency of XLEN cycles from the accept edge, or 32 cycles at the default width.
- Fast paths: `done`=1 in the cycle after E0, a latency of 1.
- `done` lasts exactly one cycle unless a new fast-path op is accepted in the DONE cycle.
- Back-to-back operation: a `start` in the DONE cycle gives a throughput of one op per XLEN+1 cycles.
- `ready`, `busy` and `done` are pure functions of the state register. No output has a combinational path from any input.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `done` exactly 32 cycles after accept, `result` = 0xFFFFFFEB. Check that `busy` is high for 32 cycles.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- Signed and unsigned divide:
  - DIV −7 / 2 → 0xFFFFFFFD.
  - REM −7 % 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - Run these back-to-back with `start` asserted in each DONE cycle; no cycle is lost.
- Fast paths:
  - DIVU 5 / 0 → 0xFFFFFFFF, and REM 5 % 0 → 5, each with `done` one cycle after accept.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM of the same operands → 0.
- Flush and ignored start: `flush` at cycle 10 of a MUL → IDLE next cycle, no `done`, `result` keeps its old value. A `start` pulsed during CALC is ignored, with no extra `done`.
- Reset and width parameter:
  - `rst_n` low mid-DIV → `ready`=1, `busy`=0, `done`=0, `result`=0 with no wait for a clock edge.
  - Instance with XLEN=8: DIV 0x80 / 0xFF → 0x80 after 1 cycle; MUL 0x0F × 0x0F → 0xE1 after 8 cycles.

Source files
------------

// File: rtl/mul_div_if.sv
// Request/response bundle between the execute stage and the M-extension unit.
// The pipeline side (master) drives the decoded operation and flush; the unit
// (slave) reports its state and the registered result.
interface mul_div_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            ready;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, src_a, src_b, flush,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, funct3, src_a, src_b, flush,
    output ready, busy, done, result
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M/RV64M execute unit. Operands are converted to magnitudes on
// accept, a shared 2*XLEN accumulator runs either radix-2 shift-add multiply
// or restoring division (one bit per cycle), and the sign is applied when the
// final step is written into the result register. Divide-by-zero and signed
// overflow are resolved on the accept edge and skip the iteration entirely.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mul_div_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [2:0]          op_r;
  logic                neg_r;
  logic [XLEN-1:0]     opb_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     result_r;

  logic                is_div_s;
  logic                a_signed_s;
  logic                b_signed_s;
  logic                a_neg_s;
  logic                b_neg_s;
  logic [XLEN-1:0]     mag_a_s;
  logic [XLEN-1:0]     mag_b_s;
  logic                res_neg_s;
  logic                div_zero_s;
  logic                div_ovf_s;
  logic                fast_s;
  logic [XLEN-1:0]     fast_res_s;
  logic                accept_s;
  logic                last_step_s;
  logic [XLEN:0]       sum_s;
  logic [XLEN:0]       shifted_s;
  logic [XLEN:0]       diff_s;
  logic [2*XLEN-1:0]   acc_nxt_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     final_res_s;

  // Two's-complement negate of an XLEN value when neg is set.
  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Two's-complement negate of a full 2*XLEN product when neg is set.
  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Decode the incoming request: operand signedness, magnitudes, result sign, fast paths.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (bus.funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      3'b010:  a_signed_s = 1'b1;
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    is_div_s   = bus.funct3[2];
    a_neg_s    = a_signed_s & bus.src_a[XLEN-1];
    b_neg_s    = b_signed_s & bus.src_b[XLEN-1];
    mag_a_s    = cond_neg(bus.src_a, a_neg_s);
    mag_b_s    = cond_neg(bus.src_b, b_neg_s);
    // Remainder takes the dividend's sign; products and quotients take a^b.
    if (is_div_s & bus.funct3[1]) begin
      res_neg_s = a_neg_s;
    end else begin
      res_neg_s = a_neg_s ^ b_neg_s;
    end
    div_zero_s = is_div_s & (bus.src_b == {XLEN{1'b0}});
    div_ovf_s  = is_div_s & ~bus.funct3[0] &
                 (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.src_b == {XLEN{1'b1}});
    fast_s     = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      fast_res_s = bus.funct3[1] ? bus.src_a : {XLEN{1'b1}};
    end else if (div_ovf_s) begin
      fast_res_s = bus.funct3[1] ? {XLEN{1'b0}} : bus.src_a;
    end else begin
      fast_res_s = {XLEN{1'b0}};
    end
    accept_s    = bus.start & ~bus.flush & (state_r != CALC);
    last_step_s = (cnt_r == CNT_W'(XLEN - 1));
  end

  // One iteration of the datapath and the sign-corrected result of the final step.
  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, high half the partial sum.
    sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
    // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
    shifted_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, opb_r};
    if (op_r[2]) begin
      if (diff_s[XLEN]) begin
        acc_nxt_s = {shifted_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
      end else begin
        acc_nxt_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_nxt_s = {sum_s, acc_r[XLEN-1:1]};
    end
    prod_s = cond_neg2(acc_nxt_s, neg_r);
    if (op_r[2]) begin
      if (op_r[1]) begin
        final_res_s = cond_neg(acc_nxt_s[2*XLEN-1:XLEN], neg_r);
      end else begin
        final_res_s = cond_neg(acc_nxt_s[XLEN-1:0], neg_r);
      end
    end else if (op_r[1:0] == 2'b00) begin
      final_res_s = prod_s[XLEN-1:0];
    end else begin
      final_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush wins over everything including a new start.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            state_nxt_s = fast_s ? DONE : CALC;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        CALC: begin
          if (last_step_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = CALC;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand latch, iteration and result register; flush leaves result untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      op_r     <= 3'b000;
      neg_r    <= 1'b0;
      opb_r    <= {XLEN{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      result_r <= {XLEN{1'b0}};
    end else if (bus.flush) begin
      cnt_r <= cnt_r;
    end else if (accept_s) begin
      cnt_r <= {CNT_W{1'b0}};
      op_r  <= bus.funct3;
      neg_r <= res_neg_s;
      if (is_div_s) begin
        opb_r <= mag_b_s;
        acc_r <= {{XLEN{1'b0}}, mag_a_s};
      end else begin
        opb_r <= mag_a_s;
        acc_r <= {{XLEN{1'b0}}, mag_b_s};
      end
      if (fast_s) begin
        result_r <= fast_res_s;
      end
    end else if (state_r == CALC) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_r + CNT_W'(1);
      if (last_step_s) begin
        result_r <= final_res_s;
      end
    end
  end

  assign bus.ready  = (state_r != CALC);
  assign bus.busy   = (state_r == CALC);
  assign bus.done   = (state_r == DONE);
  assign bus.result = result_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit. Expected results come from
// wide signed/unsigned arithmetic; expected timing comes from the accept edge
// plus the fixed latency. One compare process checks the 32-bit instance on
// every cycle; an 8-bit instance is exercised with literal expectations.
module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_div_if #(.XLEN(32)) bus32 ();
  mul_div_if #(.XLEN(8))  bus8 ();

  mul_div_unit #(.XLEN(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
  mul_div_unit #(.XLEN(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          due;
    bit          fast;
    int          kill;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] held = 32'd0;
  bit          exp_done;
  bit          exp_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from plain arithmetic at width w.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
    logic [127:0] mask, ua, ub, r;
    logic signed [127:0] sa, sb;
    mask = (128'd1 << w) - 128'd1;
    ua = {96'd0, a} & mask;
    ub = {96'd0, b} & mask;
    sa = $signed(ua << (128 - w)) >>> (128 - w);
    sb = $signed(ub << (128 - w)) >>> (128 - w);
    r  = 128'd0;
    case (f3)
      3'b000: r = sa * sb;
      3'b001: r = (sa * sb) >>> w;
      3'b010: r = (sa * $signed(ub)) >>> w;
      3'b011: r = (ua * ub) >> w;
      3'b100: if (ub == 0) r = mask; else r = sa / sb;
      3'b101: if (ub == 0) r = mask; else r = ua / ub;
      3'b110: if (ub == 0) r = ua;   else r = sa % sb;
      default: if (ub == 0) r = ua;  else r = ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  // Divide-by-zero or signed-overflow requests complete without iterating.
  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input int w);
    logic [63:0] m, aa, bb;
    m  = (64'd1 << w) - 64'd1;
    aa = {32'd0, a} & m;
    bb = {32'd0, b} & m;
    if (f3[2] && bb == 64'd0) return 1'b1;
    if ((f3 == 3'b100 || f3 == 3'b110) && aa == (64'd1 << (w - 1)) && bb == m) return 1'b1;
    return 1'b0;
  endfunction

  // Per-cycle comparison of the 32-bit instance against the expected schedule.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (rst_n) begin
      while (q.size() > 0 && q[0].kill <= cyc) void'(q.pop_front());
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      exp_busy = (q.size() > 0) && !q[0].fast && (cyc >= q[0].acc) && (cyc < q[0].due);
      chk("done",  {31'd0, bus32.done},  {31'd0, exp_done});
      chk("busy",  {31'd0, bus32.busy},  {31'd0, exp_busy});
      chk("ready", {31'd0, bus32.ready}, {31'd0, !exp_busy});
      if (exp_done) begin
        held = q[0].res;
        void'(q.pop_front());
      end
      chk("result", bus32.result, held);
    end
  end

  // Issue one op at the current negedge; return at the negedge of its done cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int poke);
    exp_t e;
    e.fast = is_fast(f3, a, b, 32);
    e.res  = ref_op(f3, a, b, 32);
    e.acc  = cyc + 1;
    e.due  = e.acc + (e.fast ? 0 : 32);
    e.kill = 1 << 30;
    q.push_back(e);
    bus32.start = 1'b1;  bus32.funct3 = f3;  bus32.src_a = a;  bus32.src_b = b;
    @(negedge clk);
    bus32.start = 1'b0;
    while (cyc < e.due) begin
      if (!e.fast && poke > 0 && cyc == e.acc + poke) begin
        bus32.start  = 1'b1;
        bus32.funct3 = 3'($urandom);
        bus32.src_a  = $urandom;
        bus32.src_b  = $urandom;
      end
      @(negedge clk);
      bus32.start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick(input bit divisor);
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = divisor ? 32'd0 : 32'd0;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = $urandom_range(0, 15);
      4: v = -$urandom_range(1, 15);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // 8-bit instance: done must appear exactly after the expected edge.
  task automatic run8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_lit);
    int edges;
    edges = is_fast(f3, {24'd0, a}, {24'd0, b}, 8) ? 0 : 8;
    chk("ref8", ref_op(f3, {24'd0, a}, {24'd0, b}, 8), {24'd0, exp_lit});
    bus8.start = 1'b1;  bus8.funct3 = f3;  bus8.src_a = a;  bus8.src_b = b;
    for (int k = 1; k <= edges + 1; k++) begin
      @(negedge clk);
      bus8.start = 1'b0;
      chk("done8", {31'd0, bus8.done}, (k == edges + 1) ? 32'd1 : 32'd0);
    end
    chk("res8", {24'd0, bus8.result}, {24'd0, exp_lit});
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    bus32.start = 1'b0; bus32.flush = 1'b0; bus32.funct3 = 3'b000;
    bus32.src_a = 32'd0; bus32.src_b = 32'd0;
    bus8.start = 1'b0;  bus8.flush = 1'b0;  bus8.funct3 = 3'b000;
    bus8.src_a = 8'd0;  bus8.src_b = 8'd0;
    #1;
    chk("rst_ready",  {31'd0, bus32.ready}, 32'd1);
    chk("rst_busy",   {31'd0, bus32.busy},  32'd0);
    chk("rst_done",   {31'd0, bus32.done},  32'd0);
    chk("rst_result", bus32.result, 32'd0);

    // Hand-computed values pin the reference model.
    chk("ref_mul",    ref_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32), 32'hFFFF_FFEB);
    chk("ref_mulh",   ref_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32), 32'h4000_0000);
    chk("ref_mulhsu", ref_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFF);
    chk("ref_mulhu",  ref_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 32'hFFFF_FFFE);
    chk("ref_div",    ref_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFD);
    chk("ref_rem",    ref_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFF);
    chk("ref_divovf", ref_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32), 32'h8000_0000);
    chk("ref_remz",   ref_op(3'b110, 32'd5, 32'd0, 32), 32'd5);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 0);            chk("mul", bus32.result, 32'hFFFF_FFEB);
    repeat (2) @(negedge clk);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 0);    chk("mulh", bus32.result, 32'h4000_0000);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);    chk("mulhsu", bus32.result, 32'hFFFF_FFFF);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);    chk("mulhu", bus32.result, 32'hFFFF_FFFE);
    @(negedge clk);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);            chk("div", bus32.result, 32'hFFFF_FFFD);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);            chk("rem", bus32.result, 32'hFFFF_FFFF);
    run_op(3'b101, 32'hFFFF_FFF9, 32'd2, 0);            chk("divu", bus32.result, 32'h7FFF_FFFC);
    run_op(3'b101, 32'd5, 32'd0, 0);                    chk("divu_z", bus32.result, 32'hFFFF_FFFF);
    run_op(3'b110, 32'd5, 32'd0, 0);                    chk("rem_z", bus32.result, 32'd5);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);    chk("div_ovf", bus32.result, 32'h8000_0000);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);    chk("rem_ovf", bus32.result, 32'd0);
    repeat (2) @(negedge clk);
    run_op(3'b000, 32'd1234, 32'd5678, 5);              chk("poke", bus32.result, 32'd7006652);
    repeat (2) @(negedge clk);

    // Flush ten cycles into a MUL: no done, result keeps the previous value.
    e.fast = 1'b0; e.res = ref_op(3'b000, 32'd99, 32'd3, 32);
    e.acc = cyc + 1; e.due = e.acc + 32; e.kill = 1 << 30;
    q.push_back(e);
    bus32.start = 1'b1; bus32.funct3 = 3'b000; bus32.src_a = 32'd99; bus32.src_b = 32'd3;
    @(negedge clk);
    bus32.start = 1'b0;
    while (cyc < e.acc + 10) @(negedge clk);
    bus32.flush = 1'b1;
    q[q.size() - 1].kill = cyc + 1;
    @(negedge clk);
    bus32.flush = 1'b0;
    chk("flush_ready", {31'd0, bus32.ready}, 32'd1);
    chk("flush_hold",  bus32.result, 32'd7006652);
    repeat (40) @(negedge clk);

    // Randomized ops, mixing back-to-back issue, idle gaps and ignored starts.
    for (int i = 0; i < 200; i++) begin
      logic [2:0] f3;
      f3 = 3'($urandom);
      run_op(f3, pick(1'b0), pick(1'b1), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 30) : 0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a DIV.
    e.fast = 1'b0; e.res = 32'd0; e.acc = cyc + 1; e.due = e.acc + 32; e.kill = 1 << 30;
    q.push_back(e);
    bus32.start = 1'b1; bus32.funct3 = 3'b100; bus32.src_a = 32'd1000; bus32.src_b = 32'd7;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",  {31'd0, bus32.ready}, 32'd1);
    chk("arst_busy",   {31'd0, bus32.busy},  32'd0);
    chk("arst_done",   {31'd0, bus32.done},  32'd0);
    chk("arst_result", bus32.result, 32'd0);
    q.delete();
    held = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3'b111, 32'd1000, 32'd7, 0);                 chk("remu", bus32.result, 32'd6);
    repeat (2) @(negedge clk);

    run8(3'b100, 8'h80, 8'hFF, 8'h80);
    run8(3'b000, 8'h0F, 8'h0F, 8'hE1);
    run8(3'b001, 8'h80, 8'h80, 8'h40);
    run8(3'b110, 8'hF9, 8'h02, 8'hFF);
    run8(3'b101, 8'h05, 8'h00, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
